// File: rtl/irq_pkg.sv
// Shared definitions for the 16-source interrupt path (source side and priority encoder).
package irq_pkg;
  localparam int ID_W  = 4;
  localparam int N_SRC = 1 << ID_W;

  typedef enum logic {IRQ_IDLE, IRQ_ACTIVE} irq_state_e;

  function automatic logic [N_SRC-1:0] onehot_dec(input logic [ID_W-1:0] id);
    return N_SRC'(1) << id;
  endfunction
endpackage

// File: rtl/irq_edge_sync.sv
// One interrupt source: two-flop synchronizer plus history flop for rising-edge detection.
module irq_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  output logic rise
);
  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= src;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
endmodule

// File: rtl/irq_claim_decoder.sv
// Pending capture, claim/complete decode and single-level in-service FSM for 16 interrupt sources.
module irq_claim_decoder
  import irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             claim_valid,
  input  logic [ID_W-1:0]  claim_id,
  input  logic             complete_valid,
  input  logic [ID_W-1:0]  complete_id,
  output logic [N_SRC-1:0] pending_o,
  output logic             irq_req_o,
  output logic             active_o,
  output logic [ID_W-1:0]  active_id_o,
  output logic             claim_err_o,
  output logic             complete_err_o
);
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] pending_n;
  irq_state_e       state, state_n;
  logic [ID_W-1:0]  active_id_n;
  logic             claim_err_n, complete_err_n;

  for (genvar i = 0; i < N_SRC; i++) begin : g_sync
    irq_edge_sync u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .src  (irq_src[i]),
      .rise (rise[i])
    );
  end

  // Claim is only judged in IDLE and complete only in ACTIVE, so at most one is accepted.
  always_comb begin
    state_n        = state;
    active_id_n    = active_id_o;
    clr            = '0;
    claim_err_n    = 1'b0;
    complete_err_n = 1'b0;
    case (state)
      IRQ_IDLE: begin
        if (claim_valid) begin
          if (pending_o[claim_id]) begin
            state_n     = IRQ_ACTIVE;
            active_id_n = claim_id;
            clr         = onehot_dec(claim_id);
          end else begin
            claim_err_n = 1'b1;
          end
        end
        if (complete_valid) complete_err_n = 1'b1;
      end
      IRQ_ACTIVE: begin
        if (complete_valid) begin
          if (complete_id == active_id_o) begin
            state_n     = IRQ_IDLE;
            active_id_n = '0;
          end else begin
            complete_err_n = 1'b1;
          end
        end
        if (claim_valid) claim_err_n = 1'b1;
      end
      default: begin
        state_n     = IRQ_IDLE;
        active_id_n = '0;
      end
    endcase
  end

  // A new edge on the source being claimed wins over the clear.
  assign pending_n = (pending_o & ~clr) | rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IRQ_IDLE;
      active_id_o    <= '0;
      pending_o      <= '0;
      claim_err_o    <= 1'b0;
      complete_err_o <= 1'b0;
    end else begin
      state          <= state_n;
      active_id_o    <= active_id_n;
      pending_o      <= pending_n;
      claim_err_o    <= claim_err_n;
      complete_err_o <= complete_err_n;
    end
  end

  assign active_o  = (state == IRQ_ACTIVE);
  assign irq_req_o = (state == IRQ_IDLE) & (|pending_o);
endmodule
